// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file with a pending-write
// scoreboard and a self-clearing initialisation sequencer.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle writeback forwarding).
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0]     rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic                       wr_en,
    output logic                       init_busy
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0]     regs [DEPTH];
    logic [DEPTH-1:0]    pending;
    logic                run;
    logic                wr_ok;
    logic                rsv_ok;

    // True for addresses backed by real storage (in range and not the hardwired zero register)
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic in_range;
        in_range = ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
        return in_range && !(ZERO_REG && (a == '0));
    endfunction

    assign run    = (state_q == RUN);
    assign wr_ok  = run && wr_en  && addr_ok(wr_addr);
    assign rsv_ok = run && rsv_en && addr_ok(rsv_addr);

    // State register and clear pointer; reset from any state restarts the clear at entry 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state: walk every entry once in INIT, then settle in RUN
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        init_busy = 1'b0;
        unique case (state_q)
            INIT: begin
                init_busy = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // Storage: cleared one entry per cycle in INIT, written back in RUN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == INIT) begin
                regs[ptr_q] <= '0;
            end else if (wr_ok) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    // Scoreboard: writeback clears, reserve sets; reserve applied last so it wins on a collision
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (wr_ok) begin
                pending[wr_addr] <= 1'b0;
            end
            if (rsv_ok) begin
                pending[rsv_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports
    always_comb begin
        logic [ADDR_W-1:0] a;
        a        = '0;
        rd_data  = '0;
        rd_valid = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            a = rd_addr[i*ADDR_W +: ADDR_W];
            if (run) begin
                if (!addr_ok(a)) begin
                    rd_data[i*XLEN +: XLEN] = '0;
                    rd_valid[i]             = 1'b1;
                end else begin
                    rd_data[i*XLEN +: XLEN] = regs[a];
                    rd_valid[i]             = ~pending[a];
`ifdef REGFILE_BYPASS_EN
                    // Forward the writeback; a same-cycle reserve keeps validity tied to the scoreboard
                    if (wr_ok && (a == wr_addr)) begin
                        rd_data[i*XLEN +: XLEN] = wr_data;
                        if (!(rsv_ok && (rsv_addr == wr_addr))) begin
                            rd_valid[i] = 1'b1;
                        end
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        init_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rsv_addr(rsv_addr), .rsv_en(rsv_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .init_busy(init_busy)
    );

    typedef struct {
        logic [4:0]  a0, a1;
        logic        rsv;
        logic [4:0]  rsv_a;
        logic        wr;
        logic [4:0]  wr_a;
        logic [31:0] wd;
        logic [31:0] d0;
        logic        v0;
        logic [31:0] d1;
        logic        v1;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [31:0] pick(input logic [31:0] nb, input logic [31:0] b);
        return BYP ? b : nb;
    endfunction

    function automatic logic pickb(input logic nb, input logic b);
        return BYP ? b : nb;
    endfunction

    function automatic vec_t mk(input logic [4:0] a0, input logic [4:0] a1,
                                input logic rsv, input logic [4:0] rsv_a,
                                input logic wr, input logic [4:0] wr_a, input logic [31:0] wd,
                                input logic [31:0] d0, input logic v0,
                                input logic [31:0] d1, input logic v1);
        vec_t v;
        v.a0 = a0; v.a1 = a1; v.rsv = rsv; v.rsv_a = rsv_a;
        v.wr = wr; v.wr_a = wr_a; v.wd = wd;
        v.d0 = d0; v.v0 = v0; v.d1 = d1; v.v1 = v1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rsv_en = 1'b0; rsv_addr = '0;
        wr_en  = 1'b0; wr_addr  = '0; wr_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts INIT cycles, checking outputs stay blank; optionally hammers wr/rsv meanwhile
    task automatic count_init(input string name, input bit pulse);
        int cnt;
        cnt = 0;
        while (init_busy === 1'b1 && cnt < 100) begin
            rd_addr = {5'(cnt + 1), 5'(cnt)};
            #1;
            chk($sformatf("%s valid c%0d", name, cnt), 32'(rd_valid), 32'h0);
            chk($sformatf("%s data c%0d", name, cnt), rd_data[31:0] | rd_data[63:32], 32'h0);
            cnt++;
            if (pulse) begin
                wr_en = 1'b1; wr_addr = 5'(cnt); wr_data = 32'hBAD0_0000 | 32'(cnt);
                rsv_en = 1'b1; rsv_addr = 5'(cnt + 3);
            end
            @(posedge clk);
            #1;
        end
        idle();
        chk({name, " cycles"}, 32'(cnt), 32'd32);
    endtask

    task automatic read_all_zero(input string name);
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            chk($sformatf("%s d0 x%0d", name, a), rd_data[31:0], 32'h0);
            chk($sformatf("%s v0 x%0d", name, a), 32'(rd_valid[0]), 32'h1);
            chk($sformatf("%s d1 x%0d", name, 31 - a), rd_data[63:32], 32'h0);
            chk($sformatf("%s v1 x%0d", name, 31 - a), 32'(rd_valid[1]), 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //               a0 a1 rsv ra wr wa  wd            d0                              v0            d1                          v1
        vecs[0]  = mk(5, 0, 0, 0, 1, 5, 32'hDEADBEEF, pick(32'h0, 32'hDEADBEEF),      1'b1,        32'h0,                      1'b1);
        vecs[1]  = mk(5, 0, 0, 0, 0, 0, 32'h0,        32'hDEADBEEF,                   1'b1,        32'h0,                      1'b1);
        vecs[2]  = mk(0, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 32'h0,                          1'b1,        32'h0,                      1'b1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,                          1'b1,        32'h0,                      1'b1);
        vecs[4]  = mk(7, 7, 1, 7, 0, 0, 32'h0,        32'h0,                          1'b1,        32'h0,                      1'b1);
        vecs[5]  = mk(7, 7, 0, 0, 0, 0, 32'h0,        32'h0,                          1'b0,        32'h0,                      1'b0);
        vecs[6]  = mk(7, 7, 0, 0, 1, 7, 32'h1234,     pick(32'h0, 32'h1234),          pickb(0, 1), pick(32'h0, 32'h1234),      pickb(0, 1));
        vecs[7]  = mk(7, 7, 0, 0, 0, 0, 32'h0,        32'h1234,                       1'b1,        32'h1234,                   1'b1);
        vecs[8]  = mk(9, 5, 1, 9, 1, 9, 32'hA5A5A5A5, pick(32'h0, 32'hA5A5A5A5),      1'b1,        32'hDEADBEEF,               1'b1);
        vecs[9]  = mk(9, 9, 0, 0, 0, 0, 32'h0,        32'hA5A5A5A5,                   1'b0,        32'hA5A5A5A5,               1'b0);
        vecs[10] = mk(9, 7, 0, 0, 1, 9, 32'h1,        pick(32'hA5A5A5A5, 32'h1),      pickb(0, 1), 32'h1234,                   1'b1);
        vecs[11] = mk(9, 9, 0, 0, 0, 0, 32'h0,        32'h1,                          1'b1,        32'h1,                      1'b1);
        vecs[12] = mk(5, 9, 0, 0, 1, 5, 32'h55,       pick(32'hDEADBEEF, 32'h55),     1'b1,        32'h1,                      1'b1);
        vecs[13] = mk(5, 5, 0, 0, 0, 0, 32'h0,        32'h55,                         1'b1,        32'h55,                     1'b1);
        vecs[14] = mk(10, 11, 1, 10, 1, 11, 32'hCAFE, 32'h0,                          1'b1,        pick(32'h0, 32'hCAFE),      1'b1);
        vecs[15] = mk(10, 11, 0, 0, 0, 0, 32'h0,      32'h0,                          1'b0,        32'hCAFE,                   1'b1);

        // Power-on reset held for three cycles, then the clearing sequence
        idle();
        rst_n   = 1'b0;
        rd_addr = {5'd1, 5'd0};
        repeat (3) tick();
        chk("reset init_busy", 32'(init_busy), 32'h1);
        chk("reset rd_valid", 32'(rd_valid), 32'h0);
        chk("reset rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
        rst_n = 1'b1;
        count_init("init1", 1'b0);
        read_all_zero("post-init1");

        // Table-driven RUN-mode vectors: outputs sampled before the edge that commits the inputs
        tick();
        for (int i = 0; i < 16; i++) begin
            rd_addr  = {vecs[i].a1, vecs[i].a0};
            rsv_en   = vecs[i].rsv; rsv_addr = vecs[i].rsv_a;
            wr_en    = vecs[i].wr;  wr_addr  = vecs[i].wr_a; wr_data = vecs[i].wd;
            #1;
            chk($sformatf("v%0d d0", i), rd_data[31:0],          vecs[i].d0);
            chk($sformatf("v%0d v0", i), 32'(rd_valid[0]),       32'(vecs[i].v0));
            chk($sformatf("v%0d d1", i), rd_data[63:32],         vecs[i].d1);
            chk($sformatf("v%0d v1", i), 32'(rd_valid[1]),       32'(vecs[i].v1));
            tick();
        end
        idle();

        // Stream writes, reserve x3 after it has been written, then reset mid-stream
        tick();
        for (int i = 1; i <= 15; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h100 + 32'(i);
            rsv_en = (i == 5); rsv_addr = 5'd3;
            tick();
        end
        idle();
        rd_addr = {5'd3, 5'd1};
        #1;
        chk("stream x1 data", rd_data[31:0], 32'h101);
        chk("stream x1 valid", 32'(rd_valid[0]), 32'h1);
        chk("stream x3 data", rd_data[63:32], 32'h103);
        chk("stream x3 valid", 32'(rd_valid[1]), 32'h0);
        tick();
        wr_en = 1'b1; wr_addr = 5'd16; wr_data = 32'h116;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_init("init2", 1'b1);
        read_all_zero("post-init2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
